// File: rtl/lsu_pkg.sv
// Shared LSU types for the post-commit store buffer.
//   - stb_entry_t : one buffered store (address, right-aligned data, size code)
//   - stb_state_t : drain FSM states
//   - STB_DW_OFFSET : low address bits ignored by the doubleword conflict check
package lsu_pkg;

  localparam int unsigned STB_ADDR_W     = 32;
  localparam int unsigned STB_DATA_W     = 64;
  localparam int unsigned LDST_TYPES_LOG = 2;
  localparam int unsigned STB_DW_OFFSET  = 3;

  typedef struct packed {
    logic [STB_ADDR_W-1:0]     addr;
    logic [STB_DATA_W-1:0]     data;
    logic [LDST_TYPES_LOG-1:0] size;
  } stb_entry_t;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StIssue   = 2'd1,
    StBackoff = 2'd2
  } stb_state_t;

endpackage

// File: rtl/stb_fifo_ram.sv
// Register array backing the store buffer FIFO.
//   clk, reset  : clock, synchronous active-high reset (clears every entry)
//   we_i        : write enable for entry waddr_i with wdata_i
//   raddr_i     : head pointer; rdata_o is the registered head entry
//   dw_addr_o   : doubleword address of every slot, for the load conflict compare
module stb_fifo_ram
  import lsu_pkg::*;
#(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned DW_W  = STB_ADDR_W - STB_DW_OFFSET
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       we_i,
  input  logic [PTR_W-1:0]           waddr_i,
  input  stb_entry_t                 wdata_i,
  input  logic [PTR_W-1:0]           raddr_i,
  output stb_entry_t                 rdata_o,
  output logic [DEPTH-1:0][DW_W-1:0] dw_addr_o
);

  stb_entry_t [DEPTH-1:0] mem_q, mem_d;

  always_comb begin
    mem_d = mem_q;
    if (we_i) begin
      mem_d[waddr_i] = wdata_i;
    end
  end

  // Entries are cleared on reset so the head outputs read zero afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata_o = mem_q[raddr_i];

  always_comb begin
    dw_addr_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      dw_addr_o[i] = mem_q[i].addr[STB_ADDR_W-1:STB_DW_OFFSET];
    end
  end

endmodule

// File: rtl/store_commit_buffer.sv
// Post-commit store buffer: in-order FIFO of committed stores drained one at a
// time into the L1 data cache write port, with miss backoff and load conflict
// detection.
//   commitSt*       : committed store input (valid/addr/data/size), ready/stall back
//   wr*, stSize_o   : cache write request driven from the head entry
//   wrHit_i         : same-cycle write completion; cacheStall_i blocks issue
//   ldEn_i/ldAddr_i : load probe; ldConflict_o asks the LSU to replay it
//   drainReq_i      : stop accepting and drain; empty_o/count_o report occupancy
module store_commit_buffer
  import lsu_pkg::*;
#(
  parameter  int unsigned DEPTH       = 8,
  parameter  int unsigned RETRY_DELAY = 4,
  localparam int unsigned ADDR_W      = STB_ADDR_W,
  localparam int unsigned DATA_W      = STB_DATA_W,
  localparam int unsigned PTR_W       = $clog2(DEPTH),
  localparam int unsigned CNT_W       = PTR_W + 1,
  localparam int unsigned DW_W        = ADDR_W - STB_DW_OFFSET
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      commitStValid_i,
  input  logic [ADDR_W-1:0]         commitStAddr_i,
  input  logic [DATA_W-1:0]         commitStData_i,
  input  logic [LDST_TYPES_LOG-1:0] commitStSize_i,
  output logic                      commitStReady_o,
  output logic                      stallStCommit_o,
  output logic                      wrEn_o,
  output logic [ADDR_W-1:0]         wrAddr_o,
  output logic [DATA_W-1:0]         wrData_o,
  output logic [LDST_TYPES_LOG-1:0] stSize_o,
  input  logic                      wrHit_i,
  input  logic                      cacheStall_i,
  input  logic                      ldEn_i,
  input  logic [ADDR_W-1:0]         ldAddr_i,
  output logic                      ldConflict_o,
  input  logic                      drainReq_i,
  output logic                      empty_o,
  output logic [CNT_W-1:0]          count_o
);

  localparam int unsigned BO_W = 4;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [BO_W-1:0]  backoff_q, backoff_d;
  stb_state_t       state_q, state_d;

  logic                      push, pop;
  stb_entry_t                wr_entry, head_entry;
  logic [DEPTH-1:0][DW_W-1:0] dw_addr;
  logic [DEPTH-1:0]          conflict_vec;
  logic                      unused_ld_lo;

  assign unused_ld_lo = ^ldAddr_i[STB_DW_OFFSET-1:0];

  // Full check ignores a same-cycle pop: space frees only on the next cycle.
  assign commitStReady_o = (count_q != CNT_W'(DEPTH)) & ~drainReq_i;
  assign stallStCommit_o = (count_q == CNT_W'(DEPTH));
  assign push            = commitStValid_i & commitStReady_o;

  assign wrEn_o = (state_q == StIssue) & ~cacheStall_i;
  assign pop    = wrEn_o & wrHit_i;

  assign wr_entry = '{addr: commitStAddr_i, data: commitStData_i, size: commitStSize_i};

  stb_fifo_ram #(
    .DEPTH(DEPTH)
  ) u_ram (
    .clk      (clk),
    .reset    (reset),
    .we_i     (push),
    .waddr_i  (tail_q),
    .wdata_i  (wr_entry),
    .raddr_i  (head_q),
    .rdata_o  (head_entry),
    .dw_addr_o(dw_addr)
  );

  assign wrAddr_o = head_entry.addr;
  assign wrData_o = head_entry.data;
  assign stSize_o = head_entry.size;
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;

  always_comb begin
    head_d  = pop  ? head_q + PTR_W'(1) : head_q;
    tail_d  = push ? tail_q + PTR_W'(1) : tail_q;
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Next state looks at count_d so a store enqueued from empty issues on the
  // very next cycle, and back-to-back hits keep the FSM in StIssue.
  always_comb begin
    state_d   = state_q;
    backoff_d = backoff_q;
    unique case (state_q)
      StIdle: begin
        if (count_d != '0) state_d = StIssue;
      end
      StIssue: begin
        if (wrEn_o) begin
          if (wrHit_i) begin
            if (count_d == '0) state_d = StIdle;
          end else begin
            backoff_d = BO_W'(RETRY_DELAY);
            state_d   = StBackoff;
          end
        end
      end
      StBackoff: begin
        backoff_d = backoff_q - BO_W'(1);
        // Leaving on the last count keeps wrEn_o low for exactly RETRY_DELAY cycles.
        if (backoff_q <= BO_W'(1)) state_d = StIssue;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      backoff_q <= '0;
      state_q   <= StIdle;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      backoff_q <= backoff_d;
      state_q   <= state_d;
    end
  end

  // Slot i is live when its distance from head is below count; the entry
  // popping this cycle is still live.
  always_comb begin
    conflict_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      conflict_vec[i] = ({1'b0, PTR_W'(i) - head_q} < count_q) &&
                        (dw_addr[i] == ldAddr_i[ADDR_W-1:STB_DW_OFFSET]);
    end
  end

  assign ldConflict_o = ldEn_i & (|conflict_vec);

  // Offering a store while not ready drops it; flag that in simulation.
  assert property (@(posedge clk) disable iff (reset) commitStValid_i |-> commitStReady_o);

endmodule

// File: tb/tb_store_commit_buffer.sv
module tb_store_commit_buffer;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned RETRY = 4;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [1:0]  size;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst, valid, hit, stall, ld_en, drain;
  logic [31:0] st_addr, ld_addr;
  logic [63:0] st_data;
  logic [1:0]  st_size;

  logic        ready_o, stall_commit_o, wren_o, conflict_o, empty_o;
  logic [31:0] wraddr_o;
  logic [63:0] wrdata_o;
  logic [1:0]  size_o;
  logic [3:0]  count_o;

  store_commit_buffer #(
    .DEPTH      (DEPTH),
    .RETRY_DELAY(RETRY)
  ) dut (
    .clk            (clk),
    .reset          (rst),
    .commitStValid_i(valid),
    .commitStAddr_i (st_addr),
    .commitStData_i (st_data),
    .commitStSize_i (st_size),
    .commitStReady_o(ready_o),
    .stallStCommit_o(stall_commit_o),
    .wrEn_o         (wren_o),
    .wrAddr_o       (wraddr_o),
    .wrData_o       (wrdata_o),
    .stSize_o       (size_o),
    .wrHit_i        (hit),
    .cacheStall_i   (stall),
    .ldEn_i         (ld_en),
    .ldAddr_i       (ld_addr),
    .ldConflict_o   (conflict_o),
    .drainReq_i     (drain),
    .empty_o        (empty_o),
    .count_o        (count_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: queue of buffered stores plus cycles left before a missed store retries.
  ent_t q[$];
  int   retry_wait = 0;

  // DUT values captured at the mid-cycle sample of the last tick.
  logic        s_wren, s_ready, s_conf;
  logic [31:0] s_addr;
  logic [63:0] s_data;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge with inputs already driven: check outputs, cross the
  // posedge, update the reference, return on the following negedge.
  task automatic tick();
    bit m_ready, m_wren, m_conf;
    #1;
    m_ready = (q.size() < DEPTH) && !drain;
    m_wren  = (q.size() != 0) && (retry_wait == 0) && !stall;
    m_conf  = 1'b0;
    foreach (q[i]) if (q[i].addr[31:3] == ld_addr[31:3]) m_conf = 1'b1;
    m_conf  = m_conf && ld_en;
    check_eq("count", 64'(count_o), 64'(q.size()));
    check_eq("empty", 64'(empty_o), 64'(q.size() == 0));
    check_eq("ready", 64'(ready_o), 64'(m_ready));
    check_eq("stall_commit", 64'(stall_commit_o), 64'(q.size() == DEPTH));
    check_eq("wren", 64'(wren_o), 64'(m_wren));
    check_eq("conflict", 64'(conflict_o), 64'(m_conf));
    if (m_wren) begin
      check_eq("wraddr", 64'(wraddr_o), 64'(q[0].addr));
      check_eq("wrdata", wrdata_o, q[0].data);
      check_eq("wrsize", 64'(size_o), 64'(q[0].size));
    end
    s_wren  = wren_o;
    s_ready = ready_o;
    s_conf  = conflict_o;
    s_addr  = wraddr_o;
    s_data  = wrdata_o;
    @(posedge clk);
    if (rst) begin
      q.delete();
      retry_wait = 0;
    end else begin
      if (retry_wait > 0) retry_wait--;
      else if (m_wren && !hit) retry_wait = RETRY;
      if (m_wren && hit) void'(q.pop_front());
      if (valid && m_ready) q.push_back('{st_addr, st_data, st_size});
    end
    @(negedge clk);
  endtask

  task automatic push_tick(input logic [31:0] a, input logic [63:0] d, input logic [1:0] sz);
    valid   = 1'b1;
    st_addr = a;
    st_data = d;
    st_size = sz;
    tick();
    valid   = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    hit   = 1'b1;
    stall = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    check_eq(tag, 64'(empty_o), 64'd1);
  endtask

  initial begin
    int gap;
    rst = 1'b1; valid = 1'b0; hit = 1'b0; stall = 1'b0; ld_en = 1'b0; drain = 1'b0;
    st_addr = '0; st_data = '0; st_size = '0; ld_addr = '0;
    @(posedge clk);
    @(negedge clk);
    check_eq("rst_wraddr", 64'(wraddr_o), 64'd0);
    check_eq("rst_wrdata", wrdata_o, 64'd0);
    check_eq("rst_size", 64'(size_o), 64'd0);
    tick();
    rst = 1'b0;

    // Hit stream: three doubleword stores, one write per cycle.
    hit = 1'b1;
    push_tick(32'h1000, 64'h1111_0000_0000_1000, 2'd3);
    check_eq("hit_first_wren", 64'(wren_o), 64'd1);
    push_tick(32'h1008, 64'h1111_0000_0000_1008, 2'd3);
    push_tick(32'h1010, 64'h1111_0000_0000_1010, 2'd3);
    check_eq("hit_third_addr", 64'(s_addr), 64'h1008);
    tick();
    check_eq("hit_last_addr", 64'(s_addr), 64'h1010);
    check_eq("hit_empty", 64'(empty_o), 64'd1);

    // Miss retry: a word store misses once, then waits RETRY cycles.
    hit = 1'b0;
    push_tick(32'h2004, 64'h0000_0000_dead_beef, 2'd2);
    tick();
    check_eq("miss_first_issue", 64'(s_wren), 64'd1);
    hit = 1'b1;
    gap = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_wren) break;
      gap++;
    end
    check_eq("miss_gap", 64'(gap), 64'(RETRY));
    check_eq("miss_reissue_addr", 64'(s_addr), 64'h2004);
    check_eq("miss_reissue_data", s_data, 64'h0000_0000_dead_beef);
    check_eq("miss_popped", 64'(empty_o), 64'd1);

    // Full: eight stores while every write misses.
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) push_tick(32'h5000 + 32'(i * 8), {$urandom, $urandom}, 2'd3);
    check_eq("full_count", 64'(count_o), 64'd8);
    check_eq("full_stall", 64'(stall_commit_o), 64'd1);
    check_eq("full_ready", 64'(ready_o), 64'd0);
    hit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_wren) break;
    end
    check_eq("full_pop_ready", 64'(s_ready), 64'd0);
    check_eq("full_after_pop", 64'(count_o), 64'd7);
    drain_all("full_drained");

    // Load conflict against a byte store held by a cache stall.
    stall = 1'b1;
    push_tick(32'h3005, 64'h0000_0000_0000_00a5, 2'd0);
    ld_en = 1'b1;
    ld_addr = 32'h3000; tick(); check_eq("conf_same_dw", 64'(s_conf), 64'd1);
    ld_addr = 32'h3008; tick(); check_eq("conf_next_dw", 64'(s_conf), 64'd0);
    ld_addr = 32'h3000; stall = 1'b0; hit = 1'b1;
    tick(); check_eq("conf_popping", 64'(s_conf), 64'd1);
    tick(); check_eq("conf_after_pop", 64'(s_conf), 64'd0);
    ld_en = 1'b0;

    // Cache stall holds two entries for five cycles.
    stall = 1'b1;
    push_tick(32'h6000, 64'h6000, 2'd3);
    push_tick(32'h6008, 64'h6008, 2'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_wren", 64'(s_wren), 64'd0);
      check_eq("stall_count", 64'(count_o), 64'd2);
    end
    stall = 1'b0;
    tick();
    check_eq("stall_resume", 64'(s_wren), 64'd1);
    drain_all("stall_drained");

    // Drain request blocks enqueue until empty.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push_tick(32'h7000 + 32'(i * 8), {$urandom, $urandom}, 2'd3);
    drain = 1'b1; stall = 1'b0; hit = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (q.size() == 0) break;
      tick();
      check_eq("drain_ready", 64'(s_ready), 64'd0);
    end
    check_eq("drain_empty", 64'(empty_o), 64'd1);
    drain = 1'b0;

    // Second round, then reset while backing off.
    stall = 1'b1;
    for (int i = 0; i < 4; i++) push_tick(32'h8000 + 32'(i * 8), {$urandom, $urandom}, 2'd3);
    drain = 1'b1; stall = 1'b0; hit = 1'b0;
    tick();
    check_eq("rb_miss", 64'(s_wren), 64'd1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; drain = 1'b0;
    check_eq("rb_count", 64'(count_o), 64'd0);
    check_eq("rb_empty", 64'(empty_o), 64'd1);
    check_eq("rb_wren", 64'(wren_o), 64'd0);
    check_eq("rb_wraddr", 64'(wraddr_o), 64'd0);

    // Random traffic against the reference.
    for (int c = 0; c < 1500; c++) begin
      if (drain && q.size() == 0) drain = 1'b0;
      else if (!drain && $urandom_range(0, 99) == 0) drain = 1'b1;
      rst     = ($urandom_range(0, 399) == 0);
      valid   = (q.size() < DEPTH) && !drain && ($urandom_range(0, 99) < 60);
      st_addr = 32'h4000 + 32'($urandom_range(0, 15) << 3) + 32'($urandom_range(0, 7));
      st_data = {$urandom, $urandom};
      st_size = 2'($urandom_range(0, 3));
      hit     = ($urandom_range(0, 99) < 75);
      stall   = ($urandom_range(0, 99) < 20);
      ld_en   = $urandom_range(0, 1);
      ld_addr = 32'h4000 + 32'($urandom_range(0, 17) << 3) + 32'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; valid = 1'b0; ld_en = 1'b0; drain = 1'b0;
    drain_all("final_drained");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
    $finish;
  end

endmodule
